// File: rtl/pe_v4_pkg.sv
// Shared definitions for the pe_core_v4 processing element.
// Holds the opcode field layout, the integer instruction class, the op
// codes (unchanged from v3) and a legality helper used by the decoder.
package pe_v4_pkg;

   // Bit positions of the fields inside the 32-bit opcode word.
   localparam int unsigned OP_LSB    = 0;
   localparam int unsigned OP_W      = 5;
   localparam int unsigned CLASS_LSB = 5;
   localparam int unsigned CLASS_W   = 7;

   localparam logic [CLASS_W-1:0] CLASS_INT = 7'h01;

   localparam logic [OP_W-1:0] OP_ADD     = 5'd1;
   localparam logic [OP_W-1:0] OP_SUB     = 5'd2;
   localparam logic [OP_W-1:0] OP_MUL     = 5'd3;
   localparam logic [OP_W-1:0] OP_MAC     = 5'd4;
   localparam logic [OP_W-1:0] OP_MAX     = 5'd5;
   localparam logic [OP_W-1:0] OP_MIN     = 5'd6;
   localparam logic [OP_W-1:0] OP_RELU    = 5'd7;
   localparam logic [OP_W-1:0] OP_ACC     = 5'd8;
   localparam logic [OP_W-1:0] OP_ACC_CLR = 5'd9;

   // Op codes are contiguous, so a range test covers every listed op.
   function automatic logic is_legal(input logic [CLASS_W-1:0] cls,
                                     input logic [OP_W-1:0]    op);
      return (cls == CLASS_INT) && (op >= OP_ADD) && (op <= OP_ACC_CLR);
   endfunction

endpackage

// File: rtl/pe_core_v4_if.sv
// Issue/result bus of pe_core_v4.
//   master : issue logic + result consumer (drives op, operands, tag,
//            valid_in, result_ready)
//   slave  : the processing element (drives ready_out and the result side)
interface pe_core_v4_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 4
);
   logic [31:0]       opcode;
   logic [DATA_W-1:0] op1;
   logic [DATA_W-1:0] op2;
   logic [DATA_W-1:0] op3;
   logic [TAG_W-1:0]  tag_in;
   logic              valid_in;
   logic              ready_out;
   logic [DATA_W-1:0] result_out;
   logic [TAG_W-1:0]  tag_out;
   logic              err_out;
   logic              result_valid;
   logic              result_ready;

   modport master (
      output opcode, op1, op2, op3, tag_in, valid_in, result_ready,
      input  ready_out, result_out, tag_out, err_out, result_valid
   );

   modport slave (
      input  opcode, op1, op2, op3, tag_in, valid_in, result_ready,
      output ready_out, result_out, tag_out, err_out, result_valid
   );
endinterface

// File: rtl/pe_v4_sat.sv
// Narrows a wide signed value to DATA_W bits.
//   din  : wide signed value (IN_W bits)
//   dout : DATA_W-bit view; clamped to the signed DATA_W range when SAT != 0,
//          otherwise the low DATA_W bits
module pe_v4_sat #(
   parameter int unsigned IN_W   = 65,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned SAT    = 0
) (
   input  logic signed [IN_W-1:0] din,
   output logic [DATA_W-1:0]      dout
);

   // The value fits when every bit from the DATA_W sign bit upward agrees.
   logic fits;
   assign fits = (&din[IN_W-1:DATA_W-1]) | ~(|din[IN_W-1:DATA_W-1]);

   always_comb begin
      dout = din[DATA_W-1:0];
      if ((SAT != 0) && !fits) begin
         dout = din[IN_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/pe_core_v4.sv
// Two-stage pipelined integer ALU/MAC with valid/ready backpressure.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pe_core_v4_if slave port (opcode/operands/tag/valid_in in,
//                ready_out out; result_out/tag_out/err_out/result_valid out,
//                result_ready in)
// S1 decodes, flags illegal ops and forms the full-precision product.
// S2 does add/compare, the accumulator read-modify-write and the narrowing.
module pe_core_v4
   import pe_v4_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ACC_W  = 64,
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned SAT    = 0
) (
   input logic          clk,
   input logic          rst_n,
   pe_core_v4_if.slave  bus
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   // One bit over the accumulator holds every intermediate without overflow.
   localparam int unsigned WIDE_W = ACC_W + 1;

   logic en;

   // ---------------- S1: decode + product ----------------
   logic [OP_W-1:0]          op_in;
   logic [CLASS_W-1:0]       cls_in;
   logic signed [DATA_W-1:0] a_in, b_in;
   logic signed [PROD_W-1:0] prod_in;
   logic                     unused_opcode;

   assign op_in         = bus.opcode[OP_LSB +: OP_W];
   assign cls_in        = bus.opcode[CLASS_LSB +: CLASS_W];
   assign unused_opcode = ^bus.opcode[31:CLASS_LSB+CLASS_W];
   assign a_in          = bus.op1;
   assign b_in          = bus.op2;
   assign prod_in       = PROD_W'(a_in) * PROD_W'(b_in);

   logic                     s1_valid_q;
   logic [OP_W-1:0]          s1_op_q;
   logic                     s1_illegal_q;
   logic signed [DATA_W-1:0] s1_a_q, s1_b_q, s1_c_q;
   logic signed [PROD_W-1:0] s1_prod_q;
   logic [TAG_W-1:0]         s1_tag_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_op_q      <= '0;
         s1_illegal_q <= 1'b0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_c_q       <= '0;
         s1_prod_q    <= '0;
         s1_tag_q     <= '0;
      end else if (en) begin
         s1_valid_q <= bus.valid_in;
         if (bus.valid_in) begin
            s1_op_q      <= op_in;
            s1_illegal_q <= !is_legal(cls_in, op_in);
            s1_a_q       <= a_in;
            s1_b_q       <= b_in;
            s1_c_q       <= bus.op3;
            s1_prod_q    <= prod_in;
            s1_tag_q     <= bus.tag_in;
         end
      end
   end

   // ---------------- S2: execute + accumulator ----------------
   logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
   logic signed [WIDE_W-1:0] wide;
   logic [DATA_W-1:0]        res_d;

   always_comb begin
      acc_sum = acc_q + ACC_W'(s1_prod_q);
      acc_d   = acc_q;
      wide    = '0;
      case (s1_op_q)
         OP_ADD:  wide = WIDE_W'(s1_a_q) + WIDE_W'(s1_b_q);
         OP_SUB:  wide = WIDE_W'(s1_a_q) - WIDE_W'(s1_b_q);
         OP_MUL:  wide = WIDE_W'(s1_prod_q);
         OP_MAC:  wide = WIDE_W'(s1_prod_q) + WIDE_W'(s1_c_q);
         OP_MAX:  wide = (s1_a_q > s1_b_q) ? WIDE_W'(s1_a_q) : WIDE_W'(s1_b_q);
         OP_MIN:  wide = (s1_a_q < s1_b_q) ? WIDE_W'(s1_a_q) : WIDE_W'(s1_b_q);
         OP_RELU: wide = s1_a_q[DATA_W-1] ? '0 : WIDE_W'(s1_a_q);
         OP_ACC: begin
            acc_d = acc_sum;
            wide  = WIDE_W'(acc_sum);
         end
         OP_ACC_CLR: begin
            acc_d = '0;
            wide  = WIDE_W'(acc_q);
         end
         default: wide = '0;
      endcase
      // Illegal ops report zero and leave the accumulator alone.
      if (s1_illegal_q) begin
         wide  = '0;
         acc_d = acc_q;
      end
   end

   pe_v4_sat #(
      .IN_W   (WIDE_W),
      .DATA_W (DATA_W),
      .SAT    (SAT)
   ) u_sat (
      .din  (wide),
      .dout (res_d)
   );

   logic              res_valid_q;
   logic [DATA_W-1:0] res_q;
   logic [TAG_W-1:0]  tag_q;
   logic              err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid_q <= 1'b0;
         res_q       <= '0;
         tag_q       <= '0;
         err_q       <= 1'b0;
         acc_q       <= '0;
      end else if (en) begin
         res_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            res_q <= res_d;
            tag_q <= s1_tag_q;
            err_q <= s1_illegal_q;
            acc_q <= acc_d;
         end
      end
   end

   // Both stages advance together; a held result freezes the whole pipe.
   assign en               = !res_valid_q || bus.result_ready;
   assign bus.ready_out    = en;
   assign bus.result_valid = res_valid_q;
   assign bus.result_out   = res_q;
   assign bus.tag_out      = tag_q;
   assign bus.err_out      = err_q;

endmodule

// File: tb/tb_pe_core_v4.sv
// Bench for pe_core_v4: a saturating and a wrapping instance share one
// stimulus stream; a spec-level model predicts each op's result at issue.
module tb_pe_core_v4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] opcode = '0;
   logic [31:0] op1 = '0, op2 = '0, op3 = '0;
   logic [3:0]  tag_in = '0;
   logic        valid_in = 1'b0;
   logic        rr = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   bit saw_not_ready = 1'b0;

   always #5 clk = ~clk;

   pe_core_v4_if #(.DATA_W(32), .TAG_W(4)) bs ();
   pe_core_v4_if #(.DATA_W(32), .TAG_W(4)) bw ();

   assign bs.opcode = opcode;   assign bw.opcode = opcode;
   assign bs.op1 = op1;         assign bw.op1 = op1;
   assign bs.op2 = op2;         assign bw.op2 = op2;
   assign bs.op3 = op3;         assign bw.op3 = op3;
   assign bs.tag_in = tag_in;   assign bw.tag_in = tag_in;
   assign bs.valid_in = valid_in;
   assign bw.valid_in = valid_in;
   assign bs.result_ready = rr; assign bw.result_ready = rr;

   pe_core_v4 #(.DATA_W(32), .ACC_W(64), .TAG_W(4), .SAT(1)) dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bs)
   );

   pe_core_v4 #(.DATA_W(32), .ACC_W(64), .TAG_W(4), .SAT(0)) dut_w (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bw)
   );

   typedef struct {
      logic [31:0] rs;
      logic [31:0] rw;
      logic [3:0]  tag;
      logic        err;
   } exp_t;

   exp_t   q[$];
   longint acc_m = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Spec-level result: full-precision math in longint, then clamp or wrap.
   function automatic void model(input logic [6:0] cls, input logic [4:0] op,
                                 input int a, input int b, input int c,
                                 output logic [31:0] rs, output logic [31:0] rw,
                                 output logic err);
      longint w, p;
      p   = longint'(a) * longint'(b);
      w   = 0;
      err = !(cls == 7'h01 && op >= 5'd1 && op <= 5'd9);
      if (!err) begin
         case (op)
            5'd1: w = longint'(a) + longint'(b);
            5'd2: w = longint'(a) - longint'(b);
            5'd3: w = p;
            5'd4: w = p + longint'(c);
            5'd5: w = (a > b) ? a : b;
            5'd6: w = (a < b) ? a : b;
            5'd7: w = (a < 0) ? 0 : a;
            5'd8: begin acc_m = acc_m + p; w = acc_m; end
            5'd9: begin w = acc_m; acc_m = 0; end
            default: w = 0;
         endcase
      end
      rw = w[31:0];
      if (w > 64'sd2147483647)           rs = 32'h7FFF_FFFF;
      else if (w < -(64'sd2147483648))   rs = 32'h8000_0000;
      else                               rs = w[31:0];
   endfunction

   // Called at posedge+1; returns at posedge+1 after the op is taken.
   task automatic issue(input string name, input logic [6:0] cls, input logic [4:0] op,
                        input int a, input int b, input int c, input logic [3:0] tag,
                        input bit pin, input logic [31:0] lit_s, input logic [31:0] lit_w,
                        input logic lit_err);
      exp_t e;
      bit   taken = 1'b0;
      opcode   = {20'hA5C3E ^ {16'h0, tag}, cls, op};
      op1      = a;
      op2      = b;
      op3      = c;
      tag_in   = tag;
      valid_in = 1'b1;
      for (int i = 0; i < 50 && !taken; i++) begin
         @(negedge clk);
         if (bs.ready_out) taken = 1'b1;
         else @(posedge clk);
      end
      if (!taken) begin
         chk({name, "_accept_timeout"}, 64'd0, 64'd1);
      end else begin
         model(cls, op, a, b, c, e.rs, e.rw, e.err);
         e.tag = tag;
         q.push_back(e);
         if (pin) begin
            chk({name, "_model_sat"}, e.rs, lit_s);
            chk({name, "_model_wrap"}, e.rw, lit_w);
            chk({name, "_model_err"}, e.err, lit_err);
         end
         @(posedge clk);
      end
      #1 valid_in = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
      chk({name, "_drain_left"}, q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string name);
      chk({name, "_valid_s"}, bs.result_valid, 0);
      chk({name, "_valid_w"}, bw.result_valid, 0);
      chk({name, "_res_s"}, bs.result_out, 0);
      chk({name, "_tag_s"}, bs.tag_out, 0);
      chk({name, "_err_s"}, bs.err_out, 0);
      chk({name, "_res_w"}, bw.result_out, 0);
      chk({name, "_ready_s"}, bs.ready_out, 1);
      chk({name, "_ready_w"}, bw.ready_out, 1);
   endtask

   // Compare process: every cycle out of reset, outputs against the model queue.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("ready_rule_s", bs.ready_out, !bs.result_valid || rr);
         chk("ready_rule_w", bw.ready_out, !bw.result_valid || rr);
         chk("valid_w_vs_s", bw.result_valid, bs.result_valid);
         if (!bs.ready_out) saw_not_ready = 1'b1;
         if (bs.result_valid) begin
            if (q.size() == 0) begin
               chk("spurious_result_valid", 64'd1, 64'd0);
            end else begin
               chk("result_s", bs.result_out, q[0].rs);
               chk("tag_s", bs.tag_out, q[0].tag);
               chk("err_s", bs.err_out, q[0].err);
               chk("result_w", bw.result_out, q[0].rw);
               chk("tag_w", bw.tag_out, q[0].tag);
               chk("err_w", bw.err_out, q[0].err);
               if (rr) void'(q.pop_front());
            end
         end
      end
   end

   localparam logic [6:0] CI = 7'h01;

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First op and its two-edge latency.
      issue("add", CI, 5'd1, 10, 20, 0, 4'd3, 1, 32'd30, 32'd30, 1'b0);
      @(negedge clk);
      chk("lat_edge1_valid", bs.result_valid, 0);
      @(negedge clk);
      chk("lat_edge2_valid", bs.result_valid, 1);
      chk("lat_edge2_result", bs.result_out, 30);
      chk("lat_edge2_tag", bs.tag_out, 3);
      chk("lat_edge2_err", bs.err_out, 0);
      @(posedge clk);
      #1;

      // Arithmetic, boundaries and clamping, back to back.
      issue("add_ovf", CI, 5'd1, 32'h7FFF_FFFF, 1, 0, 4'd1, 1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
      issue("mac", CI, 5'd4, -3, 4, 5, 4'd2, 1, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 1'b0);
      issue("sub", CI, 5'd2, 5, 9, 0, 4'd4, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
      issue("sub_ovf", CI, 5'd2, 32'h8000_0000, 1, 0, 4'd5, 1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
      issue("mul_ovf", CI, 5'd3, 32'h0001_0000, 32'h0001_0000, 0, 4'd6, 1, 32'h7FFF_FFFF, 32'h0, 1'b0);
      issue("mul", CI, 5'd3, -7, 6, 0, 4'd7, 1, 32'hFFFF_FFD6, 32'hFFFF_FFD6, 1'b0);
      issue("max", CI, 5'd5, -5, 3, 0, 4'd8, 1, 32'd3, 32'd3, 1'b0);
      issue("min", CI, 5'd6, -5, 3, 0, 4'd9, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 1'b0);
      issue("relu_neg", CI, 5'd7, -7, 0, 0, 4'd10, 1, 32'd0, 32'd0, 1'b0);
      issue("relu_pos", CI, 5'd7, 9, 0, 0, 4'd11, 1, 32'd9, 32'd9, 1'b0);
      drain("alu");

      // Accumulator chain with no bubbles, clear, restart.
      for (int i = 0; i < 4; i++)
         issue("acc", CI, 5'd8, 2, 3, 0, 4'(i), 1, 32'(6 * (i + 1)), 32'(6 * (i + 1)), 1'b0);
      issue("acc_clr", CI, 5'd9, 0, 0, 0, 4'd4, 1, 32'd24, 32'd24, 1'b0);
      issue("acc_after_clr", CI, 5'd8, 1, 1, 0, 4'd5, 1, 32'd1, 32'd1, 1'b0);

      // Illegal opcodes leave the accumulator alone.
      issue("bad_class", 7'h02, 5'd8, 2, 3, 0, 4'd6, 1, 32'd0, 32'd0, 1'b1);
      issue("bad_op", CI, 5'h1F, 2, 3, 0, 4'd7, 1, 32'd0, 32'd0, 1'b1);
      issue("bad_op0", CI, 5'h00, 2, 3, 0, 4'd8, 1, 32'd0, 32'd0, 1'b1);
      issue("acc_after_bad", CI, 5'd8, 1, 1, 0, 4'd9, 1, 32'd2, 32'd2, 1'b0);
      drain("acc");

      // Backpressure: consumer stalls for three edges while four ops queue up.
      rr = 1'b0;
      saw_not_ready = 1'b0;
      fork
         for (int i = 0; i < 4; i++)
            issue("stall_add", CI, 5'd1, 100 * i, i, 0, 4'(8 + i), 0, '0, '0, 1'b0);
         begin
            repeat (3) @(posedge clk);
            #1 rr = 1'b1;
         end
      join
      drain("stall");
      chk("stall_ready_fell", saw_not_ready, 1);

      // Steady state with a toggling consumer.
      fork
         for (int i = 0; i < 8; i++)
            issue("toggle_mul", CI, 5'd3, i - 3, 7, 0, 4'(i), 0, '0, '0, 1'b0);
         for (int j = 0; j < 12; j++) begin
            @(posedge clk);
            #1 rr = (j % 3) != 0;
         end
      join
      rr = 1'b1;
      drain("toggle");

      // Reset with two ops in flight and acc=24.
      issue("acc_clr2", CI, 5'd9, 0, 0, 0, 4'd0, 1, 32'd2, 32'd2, 1'b0);
      for (int i = 0; i < 4; i++)
         issue("acc2", CI, 5'd8, 2, 3, 0, 4'(i), 1, 32'(6 * (i + 1)), 32'(6 * (i + 1)), 1'b0);
      drain("acc2");
      issue("inflight_add", CI, 5'd1, 1, 1, 0, 4'd1, 0, '0, '0, 1'b0);
      issue("inflight_acc", CI, 5'd8, 1, 1, 0, 4'd2, 0, '0, '0, 1'b0);
      rst_n = 1'b0;
      q.delete();
      acc_m = 0;
      @(negedge clk);
      check_reset("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_reset_no_valid", bs.result_valid, 0);
      end
      @(posedge clk);
      #1;
      issue("acc_post_reset", CI, 5'd8, 1, 1, 0, 4'd3, 1, 32'd1, 32'd1, 1'b0);
      drain("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
